// File: rtl/pipe_vector_harness_if.sv
// Stimulus/response link between the vector harness and the pipelined DUT.
interface pipe_vector_harness_if #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 7
);
  logic [IN_W-1:0]  dut_in;
  logic             dut_valid;
  logic [OUT_W-1:0] dut_out;

  modport master (output dut_in, output dut_valid, input dut_out);
  modport slave  (input dut_in, input dut_valid, output dut_out);
endinterface

// File: rtl/pipe_vector_harness.sv
// Replays stored vectors into a pipelined DUT and checks its masked responses
// LAT cycles later, tracking sticky fail, mismatch count and first failing index.
module pipe_vector_harness #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 7,
  parameter int DEPTH = 10,
  parameter int LAT   = 1,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [IN_W-1:0]      ld_vec,
  input  logic [OUT_W-1:0]     ld_exp,
  input  logic [OUT_W-1:0]     ld_mask,
  input  logic [ADDR_W:0]      cfg_count,
  input  logic                 cfg_loop,
  input  logic                 start,
  input  logic                 abort,
  pipe_vector_harness_if.master dut,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_W+7:0]    mismatch_cnt,
  output logic [ADDR_W-1:0]    first_fail_idx
);

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE    = ADDR_W'(1);
  localparam logic [4:0]        LAST_DRAIN = 5'(LAT - 1);
  localparam int unsigned       NSTAGE     = LAT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [IN_W-1:0]   mem_vec  [DEPTH];
  logic [OUT_W-1:0]  mem_exp  [DEPTH];
  logic [OUT_W-1:0]  mem_mask [DEPTH];

  logic [IN_W-1:0]   dut_in_q;
  logic              dut_valid_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   cnt_q;
  logic              loop_q;
  logic [4:0]        drain_q;
  logic              pipe_v   [LAT];
  logic [ADDR_W-1:0] pipe_idx [LAT];

  logic              fail_q;
  logic [ADDR_W+7:0] mis_cnt_q;
  logic [ADDR_W-1:0] first_q;

  logic              idle_like, start_ok, cnt_ok, last, mis;
  logic [ADDR_W-1:0] idx_nxt, tap_idx;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok  = start && !abort && idle_like;
  assign cnt_ok    = (cfg_count != '0) && (cfg_count <= DEPTH_C);
  assign last      = ({1'b0, idx_q} == (cnt_q - CNT_ONE));
  assign idx_nxt   = idx_q + IDX_ONE;
  assign tap_idx   = pipe_idx[LAT-1];
  assign mis       = pipe_v[LAT-1] &&
                     (((dut.dut_out ^ mem_exp[tap_idx]) & mem_mask[tap_idx]) != '0);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start_ok) state_d = cnt_ok ? S_RUN : S_DONE;
      S_RUN: begin
        busy = 1'b1;
        if (abort)              state_d = S_IDLE;
        else if (last && !loop_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort)                      state_d = S_IDLE;
        else if (drain_q == LAST_DRAIN) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start_ok) state_d = cnt_ok ? S_RUN : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (ld_en && idle_like && ({1'b0, ld_addr} < DEPTH_C)) begin
      mem_vec[ld_addr]  <= ld_vec;
      mem_exp[ld_addr]  <= ld_exp;
      mem_mask[ld_addr] <= ld_mask;
    end
  end

  // dut_in is loaded one edge ahead so vector 0 is already live on the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in_q    <= '0;
      dut_valid_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      drain_q     <= '0;
    end else begin
      if (start_ok && cnt_ok) begin
        cnt_q       <= cfg_count;
        loop_q      <= cfg_loop;
        idx_q       <= '0;
        dut_in_q    <= mem_vec[0];
        dut_valid_q <= 1'b1;
      end else if (state_q == S_RUN && !abort) begin
        if (last) begin
          idx_q <= '0;
          if (loop_q) begin
            dut_in_q <= mem_vec[0];
          end else begin
            dut_in_q    <= '0;
            dut_valid_q <= 1'b0;
          end
        end else begin
          idx_q    <= idx_nxt;
          dut_in_q <= mem_vec[idx_nxt];
        end
      end else begin
        dut_in_q    <= '0;
        dut_valid_q <= 1'b0;
      end
      if (state_q == S_DRAIN) drain_q <= drain_q + 5'd1;
      else                    drain_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (busy && abort)) begin
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        pipe_v[k]   <= 1'b0;
        pipe_idx[k] <= '0;
      end
    end else begin
      pipe_v[0]   <= dut_valid_q;
      pipe_idx[0] <= idx_q;
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_q    <= 1'b0;
      mis_cnt_q <= '0;
      first_q   <= '0;
    end else if (mis && !abort) begin
      if (mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 1'b1;
      if (!fail_q) begin
        fail_q  <= 1'b1;
        first_q <= tap_idx;
      end
    end
  end

  assign dut.dut_in     = dut_in_q;
  assign dut.dut_valid  = dut_valid_q;
  assign fail           = fail_q;
  assign mismatch_cnt   = mis_cnt_q;
  assign first_fail_idx = first_q;

endmodule
